// File: rtl/counter_n.sv
// Up/down step counter with a shared add/subtract datapath, optional saturation,
// a one-cycle terminal-count pulse and a sticky overflow/underflow flag.
module counter_n #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] operand;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             bound_hit;
  logic             step_event;
  logic [WIDTH-1:0] next_count;

  // Subtraction reuses the adder: count + ~step + 1. A missing carry-out means underflow.
  assign operand = dir ? step : ~step;
  assign cin     = ~dir;
  assign sum     = {1'b0, count} + {1'b0, operand} + {{WIDTH{1'b0}}, cin};

  assign bound_hit  = dir ? sum[WIDTH] : ~sum[WIDTH];
  assign step_event = en & ~load & bound_hit;

  always_comb begin
    next_count = sum[WIDTH-1:0];
    if ((SATURATE != 0) && bound_hit) begin
      next_count = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        count <= load_val;
      end else if (en) begin
        count <= next_count;
      end
      tc  <= step_event;
      // An event in the same cycle as clr_ovf keeps the flag set.
      ovf <= step_event | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_counter_n.sv
// Randomized and directed bench for counter_n: four instances (WIDTH 8/32 x wrap/saturate)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_counter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        dir;
  logic        load;
  logic        clr_ovf;
  logic [31:0] step;
  logic [31:0] load_val;

  logic [7:0]  cnt_a, cnt_b;
  logic [31:0] cnt_c, cnt_d;
  logic        tc_a, tc_b, tc_c, tc_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0]     exp_q[$];
  longint unsigned m_cnt [4];
  bit              m_tc  [4];
  bit              m_ovf [4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  counter_n #(.WIDTH(8), .SATURATE(0)) u_w8_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step[7:0]), .load(load),
    .load_val(load_val[7:0]), .clr_ovf(clr_ovf), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
  counter_n #(.WIDTH(8), .SATURATE(1)) u_w8_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step[7:0]), .load(load),
    .load_val(load_val[7:0]), .clr_ovf(clr_ovf), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
  counter_n #(.WIDTH(32), .SATURATE(0)) u_w32_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));
  counter_n #(.WIDTH(32), .SATURATE(1)) u_w32_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt_d), .tc(tc_d), .ovf(ovf_d));

  // ---------------- checking ----------------
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] dut_vec(input int i);
    case (i)
      0:       return {ovf_a, tc_a, 24'd0, cnt_a};
      1:       return {ovf_b, tc_b, 24'd0, cnt_b};
      2:       return {ovf_c, tc_c, cnt_c};
      default: return {ovf_d, tc_d, cnt_d};
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic model_step(input int i);
    int              w;
    bit              sat;
    longint unsigned maxv, st, s;
    bit              ev;
    w    = (i < 2) ? 8 : 32;
    sat  = (i == 1) || (i == 3);
    maxv = (64'd1 << w) - 1;
    ev   = 1'b0;
    if (load) begin
      m_cnt[i] = longint'(load_val) & maxv;
    end else if (en) begin
      st = longint'(step) & maxv;
      if (dir) begin
        s  = m_cnt[i] + st;
        ev = (s > maxv);
        if (ev) m_cnt[i] = sat ? maxv : s - (maxv + 1);
        else    m_cnt[i] = s;
      end else begin
        ev = (st > m_cnt[i]);
        if (ev) m_cnt[i] = sat ? 64'd0 : m_cnt[i] + (maxv + 1) - st;
        else    m_cnt[i] = m_cnt[i] - st;
      end
    end
    m_tc[i]  = ev;
    m_ovf[i] = ev || (m_ovf[i] && !clr_ovf);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic score_all();
    logic [33:0] exp, got;
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      got = dut_vec(i);
      check($sformatf("count[%0d]", i), got[31:0], exp[31:0]);
      check($sformatf("tc[%0d]", i), got[32], exp[32]);
      check($sformatf("ovf[%0d]", i), got[33], exp[33]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_cycle(input bit e, input bit d, input logic [31:0] s,
                           input bit l, input logic [31:0] lv, input bit c);
    logic [63:0] mc;
    @(negedge clk);
    en = e; dir = d; step = s; load = l; load_val = lv; clr_ovf = c;
    for (int i = 0; i < 4; i++) begin
      model_step(i);
      mc = m_cnt[i];
      exp_q.push_back({m_ovf[i], m_tc[i], mc[31:0]});
    end
    @(posedge clk);
    #1;
    score_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_cnt8", cnt_a, 8'h00);
    check("rst_async_cnt32", cnt_c, 32'h0);
    check("rst_async_tc", tc_a, 1'b0);
    check("rst_async_ovf", ovf_a, 1'b0);
    en = 1'b1; dir = 1'b1; step = 32'd3; load = 1'b1; load_val = 32'hAA; clr_ovf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) exp_q.push_back(34'd0);
      score_all();
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    step = '0; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", cnt_a, 8'h00);
    check("reset_tc", tc_b, 1'b0);
    check("reset_ovf", ovf_d, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap up through 0xFF
    run_cycle(0, 1, 32'd0, 1, 32'hFE, 0);
    run_cycle(1, 1, 32'd1, 0, 32'd0, 0);
    check("wrap_c1", cnt_a, 8'hFF); check("wrap_tc1", tc_a, 1'b0); check("wrap_ovf1", ovf_a, 1'b0);
    run_cycle(1, 1, 32'd1, 0, 32'd0, 0);
    check("wrap_c2", cnt_a, 8'h00); check("wrap_tc2", tc_a, 1'b1);
    run_cycle(1, 1, 32'd1, 0, 32'd0, 0);
    check("wrap_c3", cnt_a, 8'h01); check("wrap_tc3", tc_a, 1'b0); check("wrap_ovf3", ovf_a, 1'b1);

    // Saturating down toward zero
    run_cycle(0, 0, 32'd0, 1, 32'h03, 0);
    run_cycle(1, 0, 32'd2, 0, 32'd0, 1);
    check("sat_c1", cnt_b, 8'h01); check("sat_tc1", tc_b, 1'b0); check("sat_ovf1", ovf_b, 1'b0);
    run_cycle(1, 0, 32'd2, 0, 32'd0, 0);
    check("sat_c2", cnt_b, 8'h00); check("sat_tc2", tc_b, 1'b1);
    run_cycle(1, 0, 32'd2, 0, 32'd0, 0);
    check("sat_c3", cnt_b, 8'h00); check("sat_tc3", tc_b, 1'b1); check("sat_ovf3", ovf_b, 1'b1);

    // Load beats enable
    run_cycle(1, 1, 32'd7, 1, 32'h55, 0);
    check("prio_c", cnt_a, 8'h55); check("prio_tc", tc_a, 1'b0);
    run_cycle(1, 1, 32'd7, 0, 32'd0, 0);
    check("prio_next", cnt_a, 8'h5C);

    // Zero step in the down direction is not an underflow
    run_cycle(1, 0, 32'd0, 0, 32'd0, 1);
    check("zstep_c", cnt_a, 8'h5C); check("zstep_tc", tc_a, 1'b0); check("zstep_ovf", ovf_a, 1'b0);

    // Set wins over clear, then clear alone
    run_cycle(0, 1, 32'd0, 1, 32'hFF, 1);
    run_cycle(1, 1, 32'd1, 0, 32'd0, 1);
    check("sticky_set", ovf_a, 1'b1); check("sticky_set_sat", ovf_b, 1'b1);
    check("sticky_sat_c", cnt_b, 8'hFF);
    run_cycle(0, 1, 32'd1, 0, 32'd0, 1);
    check("sticky_clr", ovf_a, 1'b0); check("sticky_tc", tc_a, 1'b0);

    // Asynchronous reset between edges
    run_cycle(0, 1, 32'd0, 1, 32'h80, 0);
    check("pre_rst_c", cnt_a, 8'h80);
    async_reset();
    run_cycle(1, 1, 32'd4, 0, 32'd0, 0);
    check("post_rst_c", cnt_a, 8'h04);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] s, lv;
      case ($urandom_range(0, 3))
        0:       s = $urandom();
        1:       s = 32'hFFFF_FF00 | $urandom_range(0, 255);
        default: s = $urandom_range(0, 4);
      endcase
      lv = ($urandom_range(0, 1) != 0) ? $urandom() : ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFFD : 32'd2);
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, s,
                $urandom_range(0, 15) == 0, lv, $urandom_range(0, 7) == 0);
      if (n % 2500 == 1234) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
